// File: rtl/result_display_scan.sv
// result_display_scan: scans a captured complex ALU result onto a 4-digit
// multiplexed 7-segment display, alternating between the real and the
// imaginary part. A newly captured result is held on display for a minimum
// number of frames before another one is accepted.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero
// digits 3..1 of the displayed word (digit 0 is always shown).
module result_display_scan #(
  parameter int REFRESH_DIV     = 1000,
  parameter int MIN_SHOW_FRAMES = 4,
  parameter int SWAP_FRAMES     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] re_in,
  input  logic [15:0] im_in,
  input  logic        res_valid,
  output logic        res_ready,
  output logic [7:0]  seg,
  output logic [3:0]  dig,
  output logic        part_im
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW_RE = 2'd1,
    SHOW_IM = 2'd2
  } state_t;

  localparam logic [15:0] DIV_LAST  = 16'(REFRESH_DIV - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(MIN_SHOW_FRAMES - 1);
  localparam logic [7:0]  HOLD_MAX  = 8'(MIN_SHOW_FRAMES);
  localparam logic [7:0]  SWAP_LAST = 8'(SWAP_FRAMES - 1);

  state_t      r_state;
  state_t      w_stateNext;
  logic [15:0] r_divCnt;
  logic [1:0]  r_digIdx;
  logic [7:0]  r_frameCnt;
  logic [7:0]  r_holdCnt;
  logic        r_ready;
  logic [15:0] r_re;
  logic [15:0] r_im;
  logic [7:0]  r_seg;
  logic [3:0]  r_dig;

  logic        w_tick;
  logic        w_frameEnd;
  logic        w_capture;
  logic        w_swap;
  logic [15:0] w_word;
  logic [3:0]  w_nibble;
  logic [6:0]  w_glyph;
  logic        w_blank;

  assign w_tick     = (r_divCnt == DIV_LAST);
  assign w_frameEnd = w_tick && (r_digIdx == 2'd3);
  assign w_capture  = res_valid && r_ready;
  assign w_swap     = w_frameEnd && (r_frameCnt == SWAP_LAST) && (r_state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // Next state: a capture always lands in SHOW_RE and beats a coincident swap
  always_comb begin
    w_stateNext = r_state;
    if (w_capture) begin
      w_stateNext = SHOW_RE;
    end else if (w_swap) begin
      case (r_state)
        SHOW_RE: w_stateNext = SHOW_IM;
        SHOW_IM: w_stateNext = SHOW_RE;
        default: w_stateNext = r_state;
      endcase
    end
  end

  // Free-running digit scan; captures never disturb it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divCnt <= 16'd0;
      r_digIdx <= 2'd0;
    end else if (w_tick) begin
      r_divCnt <= 16'd0;
      r_digIdx <= r_digIdx + 2'd1;
    end else begin
      r_divCnt <= r_divCnt + 16'd1;
    end
  end

  // Frames since the last capture or swap, driving the real/imag alternation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frameCnt <= 8'd0;
    end else if (w_capture || w_swap) begin
      r_frameCnt <= 8'd0;
    end else if (w_frameEnd && (r_state != IDLE)) begin
      r_frameCnt <= r_frameCnt + 8'd1;
    end
  end

  // Minimum-show hold: ready drops after a capture and returns after enough frame ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_holdCnt <= 8'd0;
      r_ready   <= 1'b1;
    end else if (w_capture) begin
      r_holdCnt <= 8'd0;
      r_ready   <= 1'b0;
    end else if (w_frameEnd && (r_holdCnt != HOLD_MAX)) begin
      r_holdCnt <= r_holdCnt + 8'd1;
      if (r_holdCnt == HOLD_LAST) r_ready <= 1'b1;
    end
  end

  // Result capture; data offered while not ready is simply dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_re <= 16'd0;
      r_im <= 16'd0;
    end else if (w_capture) begin
      r_re <= re_in;
      r_im <= im_in;
    end
  end

  assign w_word   = (r_state == SHOW_IM) ? r_im : r_re;
  assign w_nibble = w_word[{r_digIdx, 2'b00} +: 4];

  // Hex to 7-segment glyph, bit order g..a
  always_comb begin
    w_glyph = 7'h00;
    case (w_nibble)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h39;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      default: w_glyph = 7'h71;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank a digit when it and every higher nibble are zero
  always_comb begin
    w_blank = 1'b0;
    case (r_digIdx)
      2'd3:    w_blank = (w_word[15:12] == 4'h0);
      2'd2:    w_blank = (w_word[15:8] == 8'h00);
      2'd1:    w_blank = (w_word[15:4] == 12'h000);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  // Registered display drive so dig and seg change together, one cycle after the index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= 8'h00;
      r_dig <= 4'hF;
    end else if (r_state == IDLE) begin
      r_seg <= 8'h00;
      r_dig <= 4'hF;
    end else begin
      r_seg <= {(r_state == SHOW_IM) && (r_digIdx == 2'd0), w_blank ? 7'h00 : w_glyph};
      r_dig <= ~(4'b0001 << r_digIdx);
    end
  end

  assign res_ready = r_ready;
  assign seg       = r_seg;
  assign dig       = r_dig;
  assign part_im   = (r_state == SHOW_IM);

endmodule

// File: tb/tb_result_display_scan.sv
// tb_result_display_scan: directed test of result_display_scan with
// REFRESH_DIV=2, MIN_SHOW_FRAMES=2, SWAP_FRAMES=3. Stimulus queues expected
// output snapshots tagged with the cycle they are due; a monitor compares
// them on the falling edge.
module tb_result_display_scan;

  localparam int OFS = 3;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'h00;
`else
  localparam logic [7:0] LZ = 8'h3F;
`endif

  typedef struct {
    int          tag;
    logic [13:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] re_in = 16'h0000;
  logic [15:0] im_in = 16'h0000;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        part_im;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  result_display_scan #(
    .REFRESH_DIV(2),
    .MIN_SHOW_FRAMES(2),
    .SWAP_FRAMES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .re_in(re_in),
    .im_in(im_in),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .seg(seg),
    .dig(dig),
    .part_im(part_im)
  );

  always #5 clk = ~clk;

  // Bench cycle count: number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  task automatic waitCyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Queue an expected snapshot for bench cycle n (n counted from reset release)
  task automatic expectAt(input int n, input string nm, input logic [7:0] s,
                          input logic [3:0] d, input logic r, input logic p);
    exp_t e;
    e.tag  = OFS + n;
    e.exp  = {s, d, r, p};
    e.name = nm;
    sb.push_back(e);
  endtask

  // Drive inputs just after edge n so they are sampled on edge n+1
  task automatic applyStimulus(input int n, input logic v, input logic [15:0] re,
                               input logic [15:0] im);
    waitCyc(OFS + n);
    res_valid = v;
    re_in     = re;
    im_in     = im;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [13:0] act;
    act = {seg, dig, res_ready, part_im};
    checks++;
    if (act !== e.exp || e.tag != cyc) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d due=%0d: got seg=%h dig=%b rdy=%b im=%b, expected seg=%h dig=%b rdy=%b im=%b",
               e.name, cyc, e.tag, act[13:6], act[5:2], act[1], act[0],
               e.exp[13:6], e.exp[5:2], e.exp[1], e.exp[0]);
    end
  endtask

  // Monitor: compare every snapshot that has come due
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      e = sb.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    $display("[TB] start");
    // Held in reset, then idle with no valid
    for (int n = -2; n <= 0; n++) expectAt(n, "rstHeld", 8'h00, 4'hF, 1'b1, 1'b0);
    expectAt(1,   "idle", 8'h00, 4'hF, 1'b1, 1'b0);
    expectAt(2,   "idle", 8'h00, 4'hF, 1'b1, 1'b0);
    expectAt(5,   "idle", 8'h00, 4'hF, 1'b1, 1'b0);
    expectAt(20,  "idle", 8'h00, 4'hF, 1'b1, 1'b0);
    expectAt(50,  "idle", 8'h00, 4'hF, 1'b1, 1'b0);
    expectAt(100, "idle", 8'h00, 4'hF, 1'b1, 1'b0);
    waitCyc(OFS);
    rst_n = 1'b1;

    // Capture 0009/0001 on a frame boundary, follow hold and both swaps
    expectAt(104, "capB",    8'h00, 4'hF, 1'b0, 1'b0);
    expectAt(105, "reDig0",  8'h6F, 4'hE, 1'b0, 1'b0);
    expectAt(106, "reDig0",  8'h6F, 4'hE, 1'b0, 1'b0);
    expectAt(107, "reDig1",  LZ,    4'hD, 1'b0, 1'b0);
    expectAt(109, "reDig2",  LZ,    4'hB, 1'b0, 1'b0);
    expectAt(111, "reDig3",  LZ,    4'h7, 1'b0, 1'b0);
    expectAt(113, "reDig0",  8'h6F, 4'hE, 1'b0, 1'b0);
    expectAt(119, "holdLow", LZ,    4'h7, 1'b0, 1'b0);
    expectAt(120, "holdUp",  LZ,    4'h7, 1'b1, 1'b0);
    expectAt(127, "preSwap", LZ,    4'h7, 1'b1, 1'b0);
    expectAt(128, "swapIm",  LZ,    4'h7, 1'b1, 1'b1);
    expectAt(129, "imDig0",  8'h86, 4'hE, 1'b1, 1'b1);
    expectAt(131, "imDig1",  LZ,    4'hD, 1'b1, 1'b1);
    expectAt(151, "preSwap", LZ,    4'h7, 1'b1, 1'b1);
    expectAt(152, "swapRe",  LZ,    4'h7, 1'b1, 1'b0);
    expectAt(153, "reAgain", 8'h6F, 4'hE, 1'b1, 1'b0);
    applyStimulus(103, 1'b1, 16'h0009, 16'h0001);
    applyStimulus(104, 1'b0, 16'h0000, 16'h0000);

    // Capture ABCD, then hold valid with new data while not ready
    expectAt(160, "capC",    LZ,    4'h7, 1'b0, 1'b0);
    expectAt(162, "xDig0",   8'h5E, 4'hE, 1'b0, 1'b0);
    expectAt(163, "xDig1",   8'h39, 4'hD, 1'b0, 1'b0);
    expectAt(165, "xDig2",   8'h7C, 4'hB, 1'b0, 1'b0);
    expectAt(167, "xDig3",   8'h77, 4'h7, 1'b0, 1'b0);
    expectAt(170, "xKept",   8'h5E, 4'hE, 1'b0, 1'b0);
    expectAt(175, "xKept",   8'h77, 4'h7, 1'b0, 1'b0);
    expectAt(176, "rdyBack", 8'h77, 4'h7, 1'b1, 1'b0);
    expectAt(177, "capY",    8'h5E, 4'hE, 1'b0, 1'b0);
    expectAt(178, "yDig0",   8'h3F, 4'hE, 1'b0, 1'b0);
    expectAt(179, "yDig1",   8'h7D, 4'hD, 1'b0, 1'b0);
    expectAt(181, "yDig2",   8'h71, 4'hB, 1'b0, 1'b0);
    expectAt(183, "yDig3",   LZ,    4'h7, 1'b0, 1'b0);
    applyStimulus(159, 1'b1, 16'hABCD, 16'h1234);
    applyStimulus(160, 1'b1, 16'h0F60, 16'h0007);
    applyStimulus(177, 1'b0, 16'h0000, 16'h0000);

    // Capture exactly when a swap is due: stays real, swap moves 3 frames out
    expectAt(199, "preCapD", LZ,    4'h7, 1'b1, 1'b0);
    expectAt(200, "capWins", LZ,    4'h7, 1'b0, 1'b0);
    expectAt(202, "zDig0",   8'h06, 4'hE, 1'b0, 1'b0);
    expectAt(204, "zDig1",   8'h5B, 4'hD, 1'b0, 1'b0);
    expectAt(206, "zDig2",   8'h66, 4'hB, 1'b0, 1'b0);
    expectAt(208, "zDig3",   8'h7F, 4'h7, 1'b0, 1'b0);
    expectAt(216, "rdyD",    8'h7F, 4'h7, 1'b1, 1'b0);
    expectAt(223, "noSwap",  8'h7F, 4'h7, 1'b1, 1'b0);
    expectAt(224, "lateSwp", 8'h7F, 4'h7, 1'b1, 1'b1);
    expectAt(225, "zImDig0", 8'hBF, 4'hE, 1'b1, 1'b1);
    expectAt(227, "zImDig1", 8'h71, 4'hD, 1'b1, 1'b1);
    expectAt(229, "zImDig2", 8'h3F, 4'hB, 1'b1, 1'b1);
    expectAt(231, "zImDig3", 8'h79, 4'h7, 1'b1, 1'b1);
    applyStimulus(199, 1'b1, 16'h8421, 16'hE0F0);
    applyStimulus(200, 1'b0, 16'h0000, 16'h0000);

    // Capture while showing the imaginary part returns to the real part
    expectAt(232, "imBefore", 8'h79, 4'h7, 1'b1, 1'b1);
    expectAt(233, "capInIm",  8'hBF, 4'hE, 1'b0, 1'b0);
    expectAt(234, "wDig0",    8'h3F, 4'hE, 1'b0, 1'b0);
    expectAt(235, "wDig1",    8'h79, 4'hD, 1'b0, 1'b0);
    expectAt(237, "wDig2",    LZ,    4'hB, 1'b0, 1'b0);
    expectAt(239, "wDig3",    LZ,    4'h7, 1'b0, 1'b0);
    applyStimulus(232, 1'b1, 16'h00E0, 16'h5555);
    applyStimulus(233, 1'b0, 16'h0000, 16'h0000);

    // Asynchronous reset in the middle of SHOW_IM, then idle again
    expectAt(259, "imPreRst", 8'h6D, 4'hD, 1'b1, 1'b1);
    expectAt(260, "rstAsync", 8'h00, 4'hF, 1'b1, 1'b0);
    expectAt(261, "rstHeld",  8'h00, 4'hF, 1'b1, 1'b0);
    expectAt(262, "rstHeld",  8'h00, 4'hF, 1'b1, 1'b0);
    expectAt(263, "postRst",  8'h00, 4'hF, 1'b1, 1'b0);
    expectAt(270, "postRst",  8'h00, 4'hF, 1'b1, 1'b0);
    expectAt(280, "postRst",  8'h00, 4'hF, 1'b1, 1'b0);
    waitCyc(OFS + 260);
    rst_n = 1'b0;
    waitCyc(OFS + 262);
    rst_n = 1'b1;

    waitCyc(OFS + 285);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s never compared: due=%0d now=%0d", e.name, e.tag, cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
